contador_mod6_core: RTL and testbench
=====================================

Name: contador_mod6_core

Overview:
- Synchronous modulo-N down counter (default N=6, values 5..0) with parallel load, count enable, synchronous clear, terminal-count and zero flags.
- Serves as the tens-of-seconds / mod-6 digit stage of the timer counter chain.
- Its tc output drives the enable of the next stage.

Parameters:
- WIDTH, 4, bit width of data and count.
- MODULUS, 6, number of states; count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- clr  input  1  synchronous active-high clear; forces count to 0.
- data  input  WIDTH  parallel load value.
- loadn  input  1  active-low synchronous load.
- en  input  1  active-high count enable (decrement).
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count (borrow): 1 when en=1 and count=0, combinational.
- zero  output  1  1 when count=0, combinational, independent of en.

Behaviour:
- Reset: clr=1 at a rising clk edge sets count=0. Therefore zero=1, and tc=en.
- Priority at each rising edge: clr > load (loadn=0) > count (en=1) > hold.
- Load:
  - If data <= MODULUS-1, count <= data.
  - If data > MODULUS-1, count <= MODULUS-1 (saturating). For example, data=6 loads 5.
  - Load ignores en.
- Count: with en=1 and loadn=1, count <= count-1. At count=0 it wraps to MODULUS-1 (0 -> 5).
- Hold: with en=0, loadn=1 and clr=0, count is unchanged.
- tc = en & (count==0). It is asserted in the same cycle the wrap will occur, so the next stage decrements on the same edge.
- zero = (count==0).
- Simultaneous events:
  - clr with loadn=0 or en=1: clr wins.
  - loadn=0 with en=1: the load wins and no decrement occurs that cycle.
- count never leaves 0..MODULUS-1, because every write path is range-checked.
- No asynchronous paths. Outputs are stable one clock after any control change.

Optional Feature:
- Macro: CONTADOR_MOD6_LOAD_ERR_EN.
- When defined:
  - An extra output port load_err (1 bit, registered) is present.
  - It is set to 1 on any edge where a load occurs with data > MODULUS-1.
  - It is cleared by clr, or by a subsequent in-range load.
- When undefined: the port is absent and out-of-range loads saturate silently. Counting behaviour is identical in both builds.

Decomposition:
- Shared package contador_pkg holds:
  - the default WIDTH and MODULUS constants;
  - a count_t typedef (logic [WIDTH-1:0]);
  - a function returning MODULUS-1.
- One sub-module is natural: contador_load_sat.
  - Combinational clamp of data to 0..MODULUS-1.
  - Outputs the clamped value plus an out-of-range flag (the flag feeds load_err).

Test Plan:
- Clear: clr=1 for 1 edge with en=1 and count=3 -> count=0, zero=1, tc=1 while en=1; with en=0 -> tc=0.
- Load and saturate:
  - loadn=0, data=4 -> count=4.
  - loadn=0, data=6 (or 15) -> count=5; load_err=1 when the macro is defined.
- Count sequence: load 5, then en=1 for 12 edges -> count 4,3,2,1,0,5,4,3,2,1,0,5. tc=1 exactly in the cycles where count=0.
- Hold: en=0, loadn=1 for 5 edges at count=2 -> count stays 2, tc=0, zero=0.
- Priority:
  - loadn=0, en=1, data=3 at count=0 -> count=3 (no wrap).
  - clr=1, loadn=0, data=4 -> count=0.
- Parameter sweep: MODULUS=10, WIDTH=4 -> wraps 0 -> 9; load data=12 -> count=9.

Source files
------------

// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants, types and helpers for the mod-N down counter
//
// Purpose: default WIDTH/MODULUS, the count type at default width, and the
// helper that turns a modulus into the highest legal count value.
// Optional feature macro used by this family: CONTADOR_MOD6_LOAD_ERR_EN.
package contador_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 6;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  // Highest value the counter may hold; also the wrap target after 0.
  function automatic int max_count(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/contador_load_sat.sv
// rtl/contador_load_sat.sv - combinational clamp of a load value to 0..MODULUS-1
//
// Purpose: keeps every load inside the counter's legal range.
// Ports:
//   data  in   WIDTH  raw parallel load value
//   sat   out  WIDTH  data clamped to MODULUS-1
//   oor   out  1      data was above MODULUS-1 (clamp applied)
module contador_load_sat
  import contador_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sat,
  output logic             oor
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(MODULUS));

  always_comb begin
    oor = (data > MAX_COUNT);
    sat = oor ? MAX_COUNT : data;
  end

endmodule

// File: rtl/contador_mod6_core.sv
// rtl/contador_mod6_core.sv - mod-N synchronous down counter with load, enable, clear and flags
//
// Purpose: one digit stage of the timer chain (default mod-6, 5..0). tc feeds
// the enable of the next stage so both move on the same edge when this stage wraps.
// Optional feature macro: CONTADOR_MOD6_LOAD_ERR_EN adds the registered load_err flag.
// Ports:
//   clk       in   1      rising-edge clock
//   clr       in   1      synchronous active-high clear (count -> 0)
//   data      in   WIDTH  parallel load value (clamped to MODULUS-1)
//   loadn     in   1      active-low synchronous load
//   en        in   1      count enable (decrement, wraps 0 -> MODULUS-1)
//   count     out  WIDTH  registered count
//   tc        out  1      en & (count == 0), combinational borrow
//   zero      out  1      count == 0, combinational
//   load_err  out  1      (macro only) last load was out of range; cleared by clr or in-range load
module contador_mod6_core
  import contador_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
`ifdef CONTADOR_MOD6_LOAD_ERR_EN
  ,output logic            load_err
`endif
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(MODULUS));

  logic [WIDTH-1:0] load_val;
  logic             load_oor;

  contador_load_sat #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_load_sat (
    .data (data),
    .sat  (load_val),
    .oor  (load_oor)
  );

  // clr > load > count > hold
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (!loadn) begin
      count <= load_val;
    end else if (en) begin
      count <= (count == '0) ? MAX_COUNT : count - WIDTH'(1);
    end
  end

  always_comb begin
    zero = (count == '0);
    tc   = en & zero;
  end

`ifdef CONTADOR_MOD6_LOAD_ERR_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      load_err <= 1'b0;
    end else if (!loadn) begin
      load_err <= load_oor;
    end
  end
`else
  // Out-of-range loads saturate silently in this build; the flag has no consumer.
  logic unused_load_oor;
  assign unused_load_oor = load_oor;
`endif

endmodule

// File: tb/tb_contador_mod6_core.sv
// tb/tb_contador_mod6_core.sv - scoreboard bench for contador_mod6_core at MODULUS 6 and 10
module tb_contador_mod6_core;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       loadn = 1'b1;
  logic       en = 1'b0;
  logic [3:0] data = 4'd0;

  logic [3:0] count6, count10;
  logic       tc6, zero6, tc10, zero10;
`ifdef CONTADOR_MOD6_LOAD_ERR_EN
  logic       lerr6, lerr10;
`endif

  always #5 clk = ~clk;

  contador_mod6_core #(.WIDTH(4), .MODULUS(6)) dut6 (
    .clk   (clk),
    .clr   (clr),
    .data  (data),
    .loadn (loadn),
    .en    (en),
    .count (count6),
    .tc    (tc6),
    .zero  (zero6)
`ifdef CONTADOR_MOD6_LOAD_ERR_EN
    ,.load_err (lerr6)
`endif
  );

  contador_mod6_core #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk   (clk),
    .clr   (clr),
    .data  (data),
    .loadn (loadn),
    .en    (en),
    .count (count10),
    .tc    (tc10),
    .zero  (zero10)
`ifdef CONTADOR_MOD6_LOAD_ERR_EN
    ,.load_err (lerr10)
`endif
  );

  typedef struct {
    int c6;
    int c10;
    bit en;
    bit le6;
    bit le10;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers, rules applied arithmetically.
  int m6 = 0, m10 = 0;
  bit le6 = 1'b0, le10 = 1'b0;

  function automatic int model_next(input int cur, input int modulus, input bit c,
                                    input bit ln, input bit e, input int d);
    if (c) return 0;
    if (!ln) return (d > modulus - 1) ? modulus - 1 : d;
    if (e) return (cur + modulus - 1) % modulus;
    return cur;
  endfunction

  function automatic bit model_err(input bit cur, input int modulus, input bit c,
                                   input bit ln, input int d);
    if (c) return 1'b0;
    if (!ln) return (d > modulus - 1);
    return cur;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit c, input bit ln, input bit e, input int d);
    exp_t x;
    @(negedge clk);
    clr = c;
    loadn = ln;
    en = e;
    data = d[3:0];
    m6 = model_next(m6, 6, c, ln, e, d);
    m10 = model_next(m10, 10, c, ln, e, d);
    le6 = model_err(le6, 6, c, ln, d);
    le10 = model_err(le10, 10, c, ln, d);
    x.c6 = m6;
    x.c10 = m10;
    x.en = e;
    x.le6 = le6;
    x.le10 = le10;
    q.push_back(x);
  endtask

  // Monitor: one expectation per edge, sampled after the edge while en is still held.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("count6", int'(count6), x.c6);
        check("zero6", int'(zero6), int'(x.c6 == 0));
        check("tc6", int'(tc6), int'(x.en && x.c6 == 0));
        check("count10", int'(count10), x.c10);
        check("zero10", int'(zero10), int'(x.c10 == 0));
        check("tc10", int'(tc10), int'(x.en && x.c10 == 0));
`ifdef CONTADOR_MOD6_LOAD_ERR_EN
        check("load_err6", int'(lerr6), int'(x.le6));
        check("load_err10", int'(lerr10), int'(x.le10));
`endif
      end
    end
  end

  initial begin
    // Clear from an unknown state, then clear at count=3 with en=1, then en=0.
    step(1, 1, 0, 0);
    step(0, 0, 0, 3);
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    // Loads: in range, just above range, far above range.
    step(0, 0, 0, 4);
    step(0, 0, 0, 6);
    step(0, 0, 0, 15);
    step(0, 0, 0, 12);
    step(0, 0, 0, 9);
    // Count sequence from 5 across two wraps.
    step(0, 0, 0, 5);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0);
    // Hold at 2.
    step(0, 0, 0, 2);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 7);
    // Load beats enable at count 0; clear beats load.
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    step(0, 1, 1, 0);
    step(1, 0, 1, 4);
    // Long count run so the mod-10 instance wraps too.
    for (int i = 0; i < 22; i++) step(0, 1, 1, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
